// File: rtl/traffic_seq_ctrl_if.sv
// traffic_seq_ctrl_if
//   Groups the road/pedestrian inputs and the lamp outputs of the traffic
//   sequencer into one bundle.
//   Signals:
//     carns    car waiting on the north-south road (level)
//     carew    car waiting on the east-west road (level)
//     ped_req  pedestrian request (a one-cycle pulse is enough)
//     lights   {gns, yns, rns, gew, yew, rew}, 1 = lamp on
//     walk     pedestrian walk lamp
//     ped_pend a latched pedestrian request is awaiting service
//   Modports: master drives the requests, slave (the controller) drives lamps.
interface traffic_seq_ctrl_if;
    logic       carns;
    logic       carew;
    logic       ped_req;
    logic [5:0] lights;
    logic       walk;
    logic       ped_pend;

    modport master (
        output carns, carew, ped_req,
        input  lights, walk, ped_pend
    );

    modport slave (
        input  carns, carew, ped_req,
        output lights, walk, ped_pend
    );
endinterface

// File: rtl/traffic_seq_ctrl.sv
// traffic_seq_ctrl
//   Two-road intersection sequencer with a pedestrian crossing phase.
//   Moore FSM GNS/YNS/ARNS/GEW/YEW/AREW/WALK with a per-state dwell counter.
//   Ports:
//     clk  system clock, all state changes on the rising edge
//     rst  synchronous active-high reset
//     bus  traffic_seq_ctrl_if.slave: carns, carew, ped_req in;
//          lights, walk, ped_pend out
module traffic_seq_ctrl #(
    parameter int unsigned W      = 6,
    parameter int unsigned MIN_G  = 4,
    parameter int unsigned MAX_G  = 10,
    parameter int unsigned YEL    = 2,
    parameter int unsigned ALLRED = 1,
    parameter int unsigned WALK_T = 3
) (
    input  logic              clk,
    input  logic              rst,
    traffic_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_GNS, S_YNS, S_ARNS, S_GEW, S_YEW, S_AREW, S_WALK
    } state_t;

    // Counter value seen in the last cycle of each fixed dwell.
    localparam logic [W-1:0] MIN_LAST  = W'(MIN_G - 1);
    localparam logic [W-1:0] MAX_LAST  = W'(MAX_G - 1);
    localparam logic [W-1:0] YEL_LAST  = W'(YEL - 1);
    localparam logic [W-1:0] AR_LAST   = W'(ALLRED - 1);
    localparam logic [W-1:0] WALK_LAST = W'(WALK_T - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           ped_pend_q, ped_pend_d;
    logic           last_ns_q, last_ns_d;   // 1 = NS was the last green before all-red

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_GNS;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            last_ns_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            last_ns_q  <= last_ns_d;
        end
    end

    // Next-state and dwell bookkeeping
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_GNS:  if (cnt_q >= MIN_LAST && (bus.carew || ped_pend_q)) state_d = S_YNS;
            S_YNS:  if (cnt_q == YEL_LAST) state_d = S_ARNS;
            S_ARNS: if (cnt_q == AR_LAST)  state_d = ped_pend_q ? S_WALK : S_GEW;
            S_GEW:  if (cnt_q == MAX_LAST ||
                        (cnt_q >= MIN_LAST && (bus.carns || ped_pend_q || !bus.carew)))
                        state_d = S_YEW;
            S_YEW:  if (cnt_q == YEL_LAST) state_d = S_AREW;
            S_AREW: if (cnt_q == AR_LAST)  state_d = ped_pend_q ? S_WALK : S_GNS;
            S_WALK: if (cnt_q == WALK_LAST) state_d = last_ns_q ? S_GEW : S_GNS;
            default: state_d = S_GNS;
        endcase

        // Counter restarts at 0 in the first cycle of every state.
        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == '1)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + W'(1);

        // Entering WALK serves the request; a request on that same edge is absorbed.
        if (state_d == S_WALK && state_q != S_WALK)
            ped_pend_d = 1'b0;
        else
            ped_pend_d = ped_pend_q | bus.ped_req;

        last_ns_d = last_ns_q;
        if (state_d == S_ARNS && state_q != S_ARNS) last_ns_d = 1'b1;
        if (state_d == S_AREW && state_q != S_AREW) last_ns_d = 1'b0;
    end

    // Moore output decode
    always_comb begin
        bus.lights   = 6'b001001;
        bus.walk     = 1'b0;
        bus.ped_pend = ped_pend_q;
        unique case (state_q)
            S_GNS:   bus.lights = 6'b100001;
            S_YNS:   bus.lights = 6'b010001;
            S_GEW:   bus.lights = 6'b001100;
            S_YEW:   bus.lights = 6'b001010;
            S_WALK:  bus.walk   = 1'b1;
            default: bus.lights = 6'b001001;
        endcase
    end

endmodule
